// File: rtl/mux_arb_if.sv
// mux_arb_if: valid/ready bundle between N upstream producers, the mux_arb
// selection stage and its single downstream consumer.
//   master : the side that drives the channels, the controls and i_ready
//   slave  : the mux_arb stage itself
interface mux_arb_if #(
    parameter int N_BITS   = 32,
    parameter int N_INPUTS = 4
);
    localparam int SEL_BITS = $clog2(N_INPUTS);

    logic                         i_mode;
    logic [SEL_BITS-1:0]          i_sel;
    logic [N_INPUTS*N_BITS-1:0]   i_data;
    logic [N_INPUTS-1:0]          i_valid;
    logic [N_INPUTS-1:0]          o_ready;
    logic                         i_flush;
    logic [N_BITS-1:0]            o_data;
    logic [SEL_BITS-1:0]          o_src;
    logic                         o_valid;
    logic                         i_ready;

    modport slave (
        input  i_mode, i_sel, i_data, i_valid, i_flush, i_ready,
        output o_ready, o_data, o_src, o_valid
    );

    modport master (
        output i_mode, i_sel, i_data, i_valid, i_flush, i_ready,
        input  o_ready, o_data, o_src, o_valid
    );
endinterface

// File: rtl/mux_arb.sv
// mux_arb: N-input registered valid/ready selection stage.
// Picks one upstream channel either by explicit select (i_mode=0) or by
// round-robin among valid channels (i_mode=1), and registers the chosen word
// into a one-deep output stage with back-pressure and synchronous flush.
// Optional feature macro: MUX_ARB_STATS_EN adds o_xfer_count, a saturating
// 16-bit count of accepted upstream transfers (cleared only by i_reset).
module mux_arb #(
    parameter int N_BITS   = 32,
    parameter int N_INPUTS = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    mux_arb_if.slave    bus
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0] o_xfer_count
`endif
);
    localparam int SEL_BITS = $clog2(N_INPUTS);

    // Saturating increment for the transfer counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // p0: combinational grant/accept decision; p1: registered output stage.
    logic                  grant_p0;
    logic [SEL_BITS-1:0]   gnt_idx_p0;
    logic [N_BITS-1:0]     gnt_data_p0;
    logic                  can_accept_p0;
    logic                  xfer_p0;

    logic [N_BITS-1:0]     data_p1;
    logic [SEL_BITS-1:0]   src_p1;
    logic                  vld_p1;
    logic [SEL_BITS-1:0]   last_p1;

    // ---- stage p0: arbitration and handshake ----

    // Grant selection: fixed select in mode 0, rotating priority after last_p1 in mode 1.
    always_comb begin : grant_sel
        int cand;
        grant_p0   = 1'b0;
        gnt_idx_p0 = '0;
        cand       = 0;
        if (bus.i_mode == 1'b0) begin
            // An out-of-range select simply matches no channel.
            for (int k = 0; k < N_INPUTS; k++) begin
                if (bus.i_sel == SEL_BITS'(k) && bus.i_valid[k]) begin
                    grant_p0   = 1'b1;
                    gnt_idx_p0 = SEL_BITS'(k);
                end
            end
        end else begin
            // Search upward from last+1, wrapping; first valid channel wins.
            for (int off = 1; off <= N_INPUTS; off++) begin
                cand = (int'(last_p1) + off) % N_INPUTS;
                if (!grant_p0 && bus.i_valid[cand]) begin
                    grant_p0   = 1'b1;
                    gnt_idx_p0 = SEL_BITS'(cand);
                end
            end
        end
    end

    // Word of the granted channel.
    always_comb begin
        gnt_data_p0 = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (gnt_idx_p0 == SEL_BITS'(k)) begin
                gnt_data_p0 = bus.i_data[k*N_BITS +: N_BITS];
            end
        end
    end

    // Output stage can take a word when empty or being drained this cycle.
    // Flush and reset both suppress the transfer.
    assign can_accept_p0 = ~vld_p1 | bus.i_ready;
    assign xfer_p0       = grant_p0 & can_accept_p0 & ~bus.i_flush & ~i_reset;

    // Per-channel ready: one-hot on the granted channel when a transfer happens.
    always_comb begin
        bus.o_ready = '0;
        if (xfer_p0) begin
            bus.o_ready[gnt_idx_p0] = 1'b1;
        end
    end

    // ---- stage p1: registered output ----

    // Output register: flush beats transfer, transfer beats drain, else hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_p1 <= '0;
            src_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (bus.i_flush) begin
            vld_p1  <= 1'b0;
        end else if (xfer_p0) begin
            data_p1 <= gnt_data_p0;
            src_p1  <= gnt_idx_p0;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && bus.i_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Round-robin pointer follows every transfer in either mode; reset makes channel 0 first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_p1 <= SEL_BITS'(N_INPUTS - 1);
        end else if (xfer_p0) begin
            last_p1 <= gnt_idx_p0;
        end
    end

    assign bus.o_data  = data_p1;
    assign bus.o_src   = src_p1;
    assign bus.o_valid = vld_p1;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] xfer_cnt_p1;

    // Saturating count of accepted upstream transfers; untouched by flush.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            xfer_cnt_p1 <= '0;
        end else if (xfer_p0) begin
            xfer_cnt_p1 <= sat_inc16(xfer_cnt_p1);
        end
    end

    assign o_xfer_count = xfer_cnt_p1;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed bench for mux_arb with N_BITS=8, N_INPUTS=4 and
// channel data {0:0A, 1:1B, 2:2C, 3:3D}.
module tb_mux_arb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] xfer_count;
`endif

    mux_arb_if #(.N_BITS(8), .N_INPUTS(4)) bus ();

    mux_arb #(.N_BITS(8), .N_INPUTS(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
`ifdef MUX_ARB_STATS_EN
        ,
        .o_xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst          = 1'b1;
        bus.i_mode   = 1'b1;
        bus.i_sel    = 2'd0;
        bus.i_data   = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        bus.i_valid  = 4'b1111;
        bus.i_flush  = 1'b0;
        bus.i_ready  = 1'b1;

        // Reset state
        step();
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data",  32'(bus.o_data),  32'd0);
        check("rst_src",   32'(bus.o_src),   32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        rst = 1'b0;
        #1;

        // Round-robin, all valid: 0,1,2,3,0,1,2,3
        check("rr_first_ready", 32'(bus.o_ready), 32'b0001);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_all_src",  32'(bus.o_src), 32'(i % 4));
            check("rr_all_data", 32'(bus.o_data), 32'((i % 4) * 8'h11 + 8'h0A));
            check("rr_all_vld",  32'(bus.o_valid), 32'd1);
        end

        // Round-robin, channels 1 and 3 only: 1,3,1,3
        bus.i_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_13_src", 32'(bus.o_src), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Asynchronous reset mid-stream clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_data",  32'(bus.o_data),  32'd0);
        check("arst_src",   32'(bus.o_src),   32'd0);
        step();
        rst = 1'b0;
        bus.i_valid = 4'b1111;
        #1;
        check("post_rst_ready", 32'(bus.o_ready), 32'b0001);
        step();
        check("post_rst_data", 32'(bus.o_data), 32'h0A);
        check("post_rst_src",  32'(bus.o_src),  32'd0);

        // Fixed select
        bus.i_mode = 1'b0;
        bus.i_sel  = 2'd2;
        #1;
        check("m0_ready", 32'(bus.o_ready), 32'b0100);
        step();
        check("m0_data", 32'(bus.o_data), 32'h2C);
        check("m0_src",  32'(bus.o_src),  32'd2);
        bus.i_sel   = 2'd1;
        bus.i_valid = 4'b1101;
        #1;
        check("m0_noval_ready", 32'(bus.o_ready), 32'd0);
        step();
        check("m0_drain_vld",  32'(bus.o_valid), 32'd0);
        check("m0_drain_data", 32'(bus.o_data),  32'h2C);

        // Back-pressure
        bus.i_sel   = 2'd3;
        bus.i_valid = 4'b1111;
        step();
        check("bp_load_data", 32'(bus.o_data), 32'h3D);
        bus.i_ready = 1'b0;
        bus.i_sel   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(bus.o_ready), 32'd0);
            step();
            check("bp_data", 32'(bus.o_data),  32'h3D);
            check("bp_src",  32'(bus.o_src),   32'd3);
            check("bp_vld",  32'(bus.o_valid), 32'd1);
        end
        bus.i_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.o_ready), 32'b0001);
        step();
        check("bp_nobubble_data", 32'(bus.o_data),  32'h0A);
        check("bp_nobubble_vld",  32'(bus.o_valid), 32'd1);

        // Flush collision: advance pointer to 1, then flush while channel 0 valid
        bus.i_mode = 1'b1;
        step();
        check("pre_flush_src", 32'(bus.o_src), 32'd1);
        bus.i_valid = 4'b0001;
        bus.i_flush = 1'b1;
        #1;
        check("flush_ready", 32'(bus.o_ready), 32'd0);
        step();
        check("flush_vld", 32'(bus.o_valid), 32'd0);
        bus.i_flush = 1'b0;
        bus.i_valid = 4'b1111;
        #1;
        check("post_flush_ready", 32'(bus.o_ready), 32'b0100);
        step();
        check("post_flush_src",  32'(bus.o_src),  32'd2);
        check("post_flush_data", 32'(bus.o_data), 32'h2C);

`ifdef MUX_ARB_STATS_EN
        // Transfer counter and saturation
        rst = 1'b1;
        #1;
        check("cnt_rst", 32'(xfer_count), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("cnt_5", 32'(xfer_count), 32'd5);
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        check("cnt_flush", 32'(xfer_count), 32'd5);
        for (int i = 0; i < 65529; i++) step();
        check("cnt_fffe", 32'(xfer_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) step();
        check("cnt_sat", 32'(xfer_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-input, registered, valid/ready selection stage: the next generation of the pipeline's 2:1 datapath mux. Selects one of `N_INPUTS` upstream channels, either by explicit select or by round-robin arbitration among valid channels. Registers the chosen word into a one-deep output stage with back-pressure. Used where several producers share one pipeline consumer, e.g. writeback or forwarding source selection.

## Interface
- `N_BITS`, 32, data width per channel.
- `N_INPUTS`, 4, channel count, ≥2. `SEL_BITS` = `$clog2(N_INPUTS)` (localparam).

- `i_clk` in 1 — single clock, rising edge.
- `i_reset` in 1 — asynchronous, active-high reset.
- `i_mode` in 1 — 0 = fixed select, 1 = round-robin.
- `i_sel` in SEL_BITS — channel index, used in mode 0 only.
- `i_data` in N_INPUTS*N_BITS — flattened channels; channel k = bits [k*N_BITS +: N_BITS].
- `i_valid` in N_INPUTS — per-channel valid.
- `o_ready` out N_INPUTS — per-channel ready (one-hot or zero).
- `i_flush` in 1 — synchronous flush of the output stage.
- `o_data` out N_BITS — registered selected word.
- `o_src` out SEL_BITS — index of the channel that produced `o_data`.
- `o_valid` out 1 — output stage holds a word.
- `i_ready` in 1 — downstream accepts `o_data`.

## Operation
- `can_accept` = `~o_valid | i_ready`.
- Grant, mode 0: `g = i_sel` if `i_sel < N_INPUTS` and `i_valid[i_sel]`; otherwise no grant. Other valid channels are ignored.
- Grant, mode 1: the first valid channel searching upward from `last+1` modulo N_INPUTS. `last` wraps from N_INPUTS-1 to 0. No valid channels means no grant.
- `o_ready[k]` = (k == g) & grant & `can_accept` & `~i_flush`. At most one bit is set.
- Transfer on channel g when `i_valid[g] & o_ready[g]`. On the next edge:
  - `o_data` ← channel g, `o_src` ← g, `o_valid` ← 1.
  - `last` ← g. This happens in both modes, so switching to round-robin continues fairly.
- `o_valid` & `i_ready` with no new transfer: `o_valid` ← 0. `o_data` and `o_src` keep their last values.
- `o_valid` & `~i_ready`: `o_data`, `o_src` and `o_valid` stay frozen. No upstream ready.
- Flush: `o_valid` ← 0 on the next edge, and no transfer occurs that cycle. Flush wins over any simultaneous transfer or drain. `last` is unchanged.
- Reset (async, any time, including mid-transfer): `o_valid`=0, `o_data`=0, `o_src`=0, `last`=N_INPUTS-1 (so channel 0 is first in round-robin). `o_ready`=0 while reset is asserted.

## Timing
- Latency: 1 cycle from accepted transfer to `o_valid`=1 with the data.
- Throughput: 1 word/cycle while `i_ready`=1. Back-to-back transfers are allowed because `can_accept` includes `i_ready`.
- `o_ready` is combinational from `i_mode`, `i_sel`, `i_valid`, `i_ready`, `i_flush` and state. Upstream must not make `i_valid` depend on `o_ready`.
- `i_mode` and `i_sel` take effect in the same cycle. No state is lost on a mode change.
- Fairness: with all channels continuously valid in mode 1, each channel is granted once every N_INPUTS transfers.

## Configuration
- `MUX_ARB_STATS_EN`
  - Defined: adds port `o_xfer_count` (out, 16). It counts accepted upstream transfers and saturates at 16'hFFFF. It is cleared only by `i_reset`; flush does not affect it.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
Bench: N_BITS=8, N_INPUTS=4, channel data {0:8'h0A, 1:8'h1B, 2:8'h2C, 3:8'h3D}.
- **Reset:** assert `i_reset` mid-stream → `o_valid`=0, `o_data`=0, `o_src`=0 immediately. After release, mode 1 with all valid → first output 8'h0A with `o_src`=0.
- **Mode 0:** `i_sel`=2, all valid, `i_ready`=1 → `o_ready`=4'b0100, `o_data`=8'h2C one cycle later. With `i_sel`=1 and `i_valid[1]`=0 → `o_ready`=0, and `o_valid` drops after draining.
- **Mode 1 fairness:** all valid, `i_ready`=1 for 8 cycles → `o_src` sequence 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid → 1,3,1,3.
- **Back-pressure:** `o_valid`=1, `i_ready`=0 for 3 cycles → `o_data` and `o_src` stable and `o_ready`=0. Raising `i_ready` with a valid channel → new word the next cycle with no bubble.
- **Flush collision:** `i_flush`=1 while channel 0 is valid and `i_ready`=1 → `o_ready`=0 and `o_valid`=0 next cycle. The next grant in mode 1 continues from the pre-flush `last`.
- **Stats (macro defined):** 5 transfers → `o_xfer_count`=5. Preload to 16'hFFFE, then 3 transfers → 16'hFFFF.
